// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: time-multiplexed MAC neuron (bias + sum x*w, shift, ReLU, saturate).
// Optional build macro LEAKY_RELU_EN selects a 1/8-slope leaky ReLU for negative sums.
`default_nettype none

module neuron_mac_seq #(
  parameter int DATA_W = 8,
  parameter int N_IN   = 8,
  parameter int ACC_W  = 20,
  parameter int SHIFT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic [DATA_W-1:0] bias_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  localparam int CNT_W = $clog2(N_IN + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic              C_SINGLE = (N_IN == 1);
  localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(N_IN - 1);
  localparam logic signed [ACC_W-1:0] C_MAX = $signed(ACC_W'((2 ** (DATA_W - 1)) - 1));
`ifdef LEAKY_RELU_EN
  localparam logic signed [ACC_W-1:0] C_MIN = $signed(ACC_W'(-(2 ** (DATA_W - 1))));
`endif

  logic [1:0]              state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_q, out_d;

  logic                      beat;
  logic                      last_beat;
  logic signed [2*DATA_W-1:0] x_ext, w_ext, prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, acc_sum, shifted;
  logic [DATA_W-1:0]         act;

  assign in_ready  = rst_n & (state_q != S_OUT);
  assign beat      = in_valid & in_ready;
  assign busy      = busy_q | beat;
  assign out_valid = out_valid_q;
  assign out_data  = out_q;

  // Operands are widened first so the product is exact at 2*DATA_W bits.
  assign x_ext    = {{DATA_W{x_in[DATA_W-1]}}, x_in};
  assign w_ext    = {{DATA_W{w_in[DATA_W-1]}}, w_in};
  assign prod     = x_ext * w_ext;
  assign prod_ext = {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign bias_ext = {{(ACC_W - DATA_W){bias_in[DATA_W-1]}}, bias_in};
  assign acc_sum  = ((state_q == S_IDLE) ? bias_ext : acc_q) + prod_ext;
  assign shifted  = acc_sum >>> SHIFT;

  assign last_beat = (state_q == S_IDLE) ? C_SINGLE : (cnt_q == C_LAST);

`ifdef LEAKY_RELU_EN
  logic signed [ACC_W-1:0] leaky;
  assign leaky = shifted >>> 3;
`endif

  always_comb begin
    act = '0;
    if (shifted > C_MAX) begin
      act = C_MAX[DATA_W-1:0];
    end else if (shifted[ACC_W-1]) begin
`ifdef LEAKY_RELU_EN
      if (leaky < C_MIN) act = C_MIN[DATA_W-1:0];
      else               act = leaky[DATA_W-1:0];
`else
      act = '0;
`endif
    end else begin
      act = shifted[DATA_W-1:0];
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    case (state_q)
      S_IDLE, S_ACC: begin
        if (beat) begin
          acc_d  = acc_sum;
          cnt_d  = (state_q == S_IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          if (last_beat) begin
            state_d     = S_OUT;
            out_d       = act;
            out_valid_d = 1'b1;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_seq.sv
// Directed bench for neuron_mac_seq: two instances (SHIFT=0 and SHIFT=4) share one stimulus stream.
`default_nettype none

module tb_neuron_mac_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] x_in, w_in, bias_in;

  logic       in_ready0, out_valid0, busy0;
  logic [7:0] out_data0;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;

  int total  = 0;
  int passed = 0;
  int failed = 0;
  int busy_cyc = 0;

  neuron_mac_seq #(.DATA_W(8), .N_IN(8), .ACC_W(20), .SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .x_in(x_in), .w_in(w_in), .bias_in(bias_in),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0)
  );

  neuron_mac_seq #(.DATA_W(8), .N_IN(8), .ACC_W(20), .SHIFT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .x_in(x_in), .w_in(w_in), .bias_in(bias_in),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded wait).
  task automatic drive_beat(input logic [7:0] x, input logic [7:0] w, input logic [7:0] b);
    int t;
    t = 0;
    in_valid = 1'b1; x_in = x; w_in = w; bias_in = b;
    #1;
    while (!in_ready0 && t < 40) begin
      @(negedge clk); #1; t++;
    end
    if (t >= 40) chk("beat_timeout", 32'd0, 32'd1);
    if (busy0) busy_cyc++;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e0, input logic [7:0] e4);
    chk({tag, "_valid0"}, out_valid0, 1'b1);
    chk({tag, "_valid4"}, out_valid4, 1'b1);
    chk({tag, "_data0"}, out_data0, e0);
    chk({tag, "_data4"}, out_data4, e4);
    if (busy0) busy_cyc++;
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk({tag, "_drop_valid"}, out_valid0, 1'b0);
    chk({tag, "_ready_back"}, in_ready0, 1'b1);
  endtask

  logic [7:0] exp_neg0, exp_neg4;

  initial begin
`ifdef LEAKY_RELU_EN
    exp_neg0 = 8'hCE;
    exp_neg4 = 8'hFC;
`else
    exp_neg0 = 8'h00;
    exp_neg4 = 8'h00;
`endif
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x_in = '0; w_in = '0; bias_in = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready0, 1'b0);
    chk("rst_out_valid", out_valid0, 1'b0);
    chk("rst_out_data", out_data0, 8'd0);
    chk("rst_busy", busy0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready0, 1'b1);

    // 8 x (2*3) + 4 = 52; with SHIFT=4 -> 3
    out_ready = 1'b1;
    busy_cyc = 0;
    repeat (8) drive_beat(8'd2, 8'd3, 8'd4);
    check_out("t1", 8'd52, 8'd3);
    chk("t1_busy_low", busy0, 1'b0);
    chk("t1_busy_cycles", busy_cyc, 32'd9);

    // -400 -> ReLU 0, leaky -50; SHIFT=4: -25 -> leaky -4
    repeat (8) drive_beat(8'hFB, 8'd10, 8'd0);
    check_out("t2", exp_neg0, exp_neg4);

    // 129159 saturates in both
    repeat (8) drive_beat(8'd127, 8'd127, 8'd127);
    check_out("t3", 8'd127, 8'd127);

    // 2048: saturate; 512: 127 / 32
    repeat (8) drive_beat(8'd16, 8'd16, 8'd0);
    check_out("t4a", 8'd127, 8'd127);
    repeat (8) drive_beat(8'd8, 8'd8, 8'd0);
    check_out("t4b", 8'd127, 8'd32);

    // Bubbled input, stalled output, held next beat during OUT
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) @(negedge clk);
      drive_beat(8'd2, 8'd3, 8'd4);
    end
    chk("t5_valid", out_valid0, 1'b1);
    in_valid = 1'b1; x_in = 8'd1; w_in = 8'd1; bias_in = 8'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("t5_hold_valid", out_valid0, 1'b1);
      chk("t5_hold_data0", out_data0, 8'd52);
      chk("t5_hold_data4", out_data4, 8'd3);
      chk("t5_hold_ready", in_ready0, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk); #1;
    chk("t5_hs_valid", out_valid0, 1'b0);
    chk("t5_hs_ready", in_ready0, 1'b1);
    repeat (8) drive_beat(8'd1, 8'd1, 8'd0);
    check_out("t5b", 8'd8, 8'd0);

    // Abort after 4 beats, then a clean neuron
    repeat (4) drive_beat(8'd10, 8'd10, 8'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", in_ready0, 1'b0);
    chk("t6_rst_valid", out_valid0, 1'b0);
    chk("t6_rst_data", out_data0, 8'd0);
    chk("t6_rst_busy", busy0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_rel_ready", in_ready0, 1'b1);
    repeat (8) drive_beat(8'd1, 8'd1, 8'd0);
    check_out("t6", 8'd8, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
